mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory/writeback stage: the single writer of the register file's write port (writeEnable/writeAddr/writeValue).
//  Accepts one retiring instruction per cycle from the MEM stage and aligns/extends load data.
//  Waits for variable-latency data-memory responses; stalls upstream while a load is outstanding.
//  Publishes the value being written as a bypass source for decode.
// PARAMETERS
//  WORD_WIDTH   32  datapath width
//  REG_NUM_LOG  5   register address width
// PORTS
//  clk              input   1              clock; all state on posedge
//  rst              input   1              asynchronous active-low reset
//  inValid          input   1              MEM stage presents an instruction
//  inReady          output  1              stage can accept (combinational: 1 in IDLE, 0 in WAIT_MEM)
//  inWriteEnable    input   1              instruction writes a register
//  inWriteAddr      input   REG_NUM_LOG    destination register
//  inAluResult      input   WORD_WIDTH     result for non-load instructions
//  inIsLoad         input   1              instruction is a load
//  inLoadType       input   3              0=LB 1=LBU 2=LH 3=LHU 4=LW; 5..7 treated as LW
//  inByteOffset     input   2              address[1:0] of the load
//  memDataValid     input   1              data memory returns read data this cycle
//  memData          input   WORD_WIDTH     raw aligned word from data memory
//  stallReq         output  1              registered; 1 while a load is outstanding
//  writeEnable      output  1              register-file write strobe (registered)
//  writeAddr        output  REG_NUM_LOG    register-file write address (registered)
//  writeValue       output  WORD_WIDTH     register-file write data (registered)
//  fwdValid         output  1              writeEnable && writeAddr!=0
//  fwdAddr          output  REG_NUM_LOG    = writeAddr
//  fwdValue         output  WORD_WIDTH     = writeValue
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; stallReq, writeEnable, writeAddr, writeValue, fwdValid = 0.
//   Pending load discarded.
//  States: IDLE, WAIT_MEM.
//  IDLE, accept = inValid && inReady:
//   - non-load: next posedge drives writeEnable=inWriteEnable, writeAddr, writeValue=inAluResult.
//   - load with memDataValid same cycle: next posedge drives extracted data; stay IDLE.
//   - load without memDataValid: latch addr/type/offset/writeEnable; -> WAIT_MEM; stallReq=1 next posedge.
//  WAIT_MEM: inReady=0; inValid ignored.
//   - on memDataValid: next posedge drives extracted data, stallReq=0, -> IDLE.
//   - stays indefinitely without memDataValid.
//  Write outputs are asserted for exactly one cycle per retired instruction; writeEnable=0 on other cycles.
//   - writeAddr/writeValue hold their last values when writeEnable=0.
//  Register file samples on negedge, so a write lands in the same cycle writeEnable is high.
//  Load latency: 1 cycle after memDataValid; non-load latency: 1 cycle after accept.
//  Extraction is big-endian: offset 0 -> memData[31:24], offset 3 -> [7:0].
//   - halfword: offset[1]=0 -> [31:16], offset[1]=1 -> [15:0]; offset[0] ignored.
//   - LB/LH sign-extend to WORD_WIDTH; LBU/LHU zero-extend; LW passes the word; offset ignored.
//  writeAddr=0: writeEnable is still driven as the instruction requests (register file ignores it); fwdValid=0.
//  memDataValid in IDLE with no load being accepted: ignored.
//  Reset during WAIT_MEM: returns to IDLE, no write issued; a later stray memDataValid is ignored.
// TESTING
//  Reset: hold rst=0 with toggling inputs -> all outputs 0, inReady=1; release -> IDLE.
//  ALU op: inWriteAddr=5, inAluResult=0x12345678 -> next cycle writeEnable=1, addr=5, value=0x12345678,
//   fwdValid=1; cycle after: writeEnable=0.
//  Load, same-cycle response: LB, offset 1, memData=0x0080FF00 -> value 0xFFFFFF80.
//   LBU same data -> 0x00000080.
//  Load, 3-cycle delayed response: LH, offset 2, memData=0x0000F00F -> stallReq=1, inReady=0 for 3 cycles;
//   one cycle after memDataValid writes 0xFFFFF00F; inValid asserted while waiting is not accepted.
//  Back-to-back: 4 consecutive ALU ops to r1..r4 -> 4 consecutive one-cycle writes, no bubbles;
//   op to r0 -> writeEnable=1, fwdValid=0.
//  Reset mid-wait: enter WAIT_MEM, drop rst -> no write; release and pulse memDataValid -> no write, stallReq=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: sole writer of the register-file write port.
// Retires one instruction per cycle from MEM, extracts/extends load data,
// waits for variable-latency data-memory responses and publishes the value
// being written as a bypass source for decode.
//
// Handshake: an instruction transfers on a cycle where inValid && inReady are
// both high at the rising edge. inReady is combinational from state only
// (high in IDLE, low in WAIT_MEM), never from inValid, so no loop forms.
// inValid is ignored while inReady is low.
module mem_wb_stage #(
  parameter int WORD_WIDTH  = 32,
  parameter int REG_NUM_LOG = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic                   inWriteEnable,
  input  logic [REG_NUM_LOG-1:0] inWriteAddr,
  input  logic [WORD_WIDTH-1:0]  inAluResult,
  input  logic                   inIsLoad,
  input  logic [2:0]             inLoadType,
  input  logic [1:0]             inByteOffset,
  input  logic                   memDataValid,
  input  logic [WORD_WIDTH-1:0]  memData,
  output logic                   stallReq,
  output logic                   writeEnable,
  output logic [REG_NUM_LOG-1:0] writeAddr,
  output logic [WORD_WIDTH-1:0]  writeValue,
  output logic                   fwdValid,
  output logic [REG_NUM_LOG-1:0] fwdAddr,
  output logic [WORD_WIDTH-1:0]  fwdValue,
  output logic                   dbg_state
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;

  state_t                 state, state_nxt;

  // Load parked while waiting for the memory response
  logic [REG_NUM_LOG-1:0] pend_addr;
  logic [2:0]             pend_type;
  logic [1:0]             pend_off;
  logic                   pend_we;

  logic                   accept;
  logic                   latch_load;
  logic                   wr_we;
  logic [REG_NUM_LOG-1:0] wr_addr;
  logic [WORD_WIDTH-1:0]  wr_val;

  // Big-endian byte/halfword selection with sign or zero extension.
  // Types 4..7 all pass the full word unchanged.
  function automatic logic [WORD_WIDTH-1:0] extract(
    input logic [2:0]            lt,
    input logic [1:0]            off,
    input logic [WORD_WIDTH-1:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [WORD_WIDTH-1:0] r;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (lt)
      LT_LB:   r = {{(WORD_WIDTH-8){b[7]}}, b};
      LT_LBU:  r = {{(WORD_WIDTH-8){1'b0}}, b};
      LT_LH:   r = {{(WORD_WIDTH-16){h[15]}}, h};
      LT_LHU:  r = {{(WORD_WIDTH-16){1'b0}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign inReady   = (state == IDLE);
  assign accept    = inValid && inReady;
  assign dbg_state = state;

  assign fwdValid  = writeEnable && (writeAddr != '0);
  assign fwdAddr   = writeAddr;
  assign fwdValue  = writeValue;

  // Next-state and retirement selection
  always_comb begin
    state_nxt  = state;
    latch_load = 1'b0;
    wr_we      = 1'b0;
    wr_addr    = inWriteAddr;
    wr_val     = inAluResult;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!inIsLoad) begin
            wr_we = inWriteEnable;
          end else if (memDataValid) begin
            wr_we  = inWriteEnable;
            wr_val = extract(inLoadType, inByteOffset, memData);
          end else begin
            latch_load = 1'b1;
            state_nxt  = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (memDataValid) begin
          wr_we     = pend_we;
          wr_addr   = pend_addr;
          wr_val    = extract(pend_type, pend_off, memData);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pending load and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      stallReq    <= 1'b0;
      writeEnable <= 1'b0;
      writeAddr   <= '0;
      writeValue  <= '0;
      pend_addr   <= '0;
      pend_type   <= '0;
      pend_off    <= '0;
      pend_we     <= 1'b0;
    end else begin
      state       <= state_nxt;
      stallReq    <= (state_nxt == WAIT_MEM);
      writeEnable <= wr_we;
      // Address/value hold between writes so the bypass bus stays stable
      if (wr_we) begin
        writeAddr  <= wr_addr;
        writeValue <= wr_val;
      end
      if (latch_load) begin
        pend_addr <= inWriteAddr;
        pend_type <= inLoadType;
        pend_off  <= inByteOffset;
        pend_we   <= inWriteEnable;
      end
    end
  end

endmodule
